alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req0/req1  input  1  operation request from requester 0/1.
REQ-005 SHALL have ports code0/code1  input  4  opcode of requester 0/1 (ALU encoding).
REQ-006 SHALL have ports x0/x1, y0/y1  input  WIDTH  operands of requester 0/1.
REQ-007 SHALL have ports done0/done1  output  1  one-cycle completion pulse to requester 0/1.
REQ-008 SHALL have port res_z  output  WIDTH  registered result of last completed op.
REQ-009 SHALL have port res_cmp  output  1  registered compare flag of last completed op.
REQ-010 SHALL have port busy  output  1  high when state is not IDLE.
REQ-011 SHALL have ports alu_code  output  4, alu_x/alu_y  output  WIDTH  drive of the shared ALU.
REQ-012 SHALL have ports alu_z  input  WIDTH, alu_cmp  input  1  shared ALU result and flag.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-014 IDLE: if any req high, SHALL select winner, latch its code/x/y and winner id, go to EXEC; else stay in IDLE.
REQ-015 EXEC: SHALL drive alu_code/alu_x/alu_y from latched values for exactly one cycle, capture alu_z into res_z and alu_cmp into res_cmp at end of cycle, go to DONE.
REQ-016 DONE: SHALL assert done of latched winner only, for exactly this cycle; go to IDLE.
REQ-017 Outside EXEC, alu_code SHALL be 4'b1111 (ALU no-op) and alu_x/alu_y SHALL be 0.
REQ-018 Latency: req sampled in IDLE at cycle t -> done pulse at t+2; next arbitration at t+3; max throughput one op per 3 cycles.
REQ-019 res_z/res_cmp SHALL hold their value until the next EXEC capture.
REQ-020 Requester SHALL hold req and operands stable until its done; operand changes after the IDLE sample SHALL NOT affect the op in flight.
REQ-021 req dropped during EXEC/DONE: op SHALL complete and done SHALL still pulse.
REQ-022 Requester keeping req high in the cycle after its done SHALL be treated as a new request.
REQ-023 done0 and done1 SHALL never be high in the same cycle.
REQ-024 Round-robin pointer SHALL point to the non-winner after every grant; on simultaneous req, pointed requester wins.
REQ-025 Single requester active SHALL win regardless of pointer.

Reset
REQ-026 rst high at a clock edge SHALL force state IDLE, pointer to requester 0, latched code to 4'b1111, latched operands, res_z and res_cmp to 0.
REQ-027 During and after reset: done0=done1=0, busy=0, alu_code=4'b1111, alu_x=alu_y=0.
REQ-028 rst mid-operation SHALL abort the op with no done pulse and no update of res_z/res_cmp beyond reset value 0.

Configuration
REQ-029 Macro ALU_ARB_RR_EN defined: round-robin arbitration per REQ-024.
REQ-030 Macro ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins simultaneous requests; pointer logic absent; all other behaviour identical.

Verification
REQ-031 req0=1, code0=0000, x0=5, y0=7 from IDLE -> busy 2 cycles later still high, done0 at t+2, res_z=12, res_cmp=0, done1 never.
REQ-032 req0 and req1 held high, code0=0001 x0=10 y0=3, code1=0010 x1=6 y1=4, RR_EN defined -> done0 (res_z=7), then done1 three cycles later (res_z=24), alternating.
REQ-033 Same as REQ-032 with ALU_ARB_RR_EN undefined -> done0 every 3 cycles, done1 never while req0 held.
REQ-034 req1=1, code1=1010, x1=2, y1=9 -> done1 at t+2, res_cmp=1, res_z=0; alu_code=4'b1111 in all non-EXEC cycles.
REQ-035 req0=1, x0 changed from 3 to 8 during EXEC (code0=0000, y0=1) -> res_z=4.
REQ-036 rst asserted in EXEC cycle -> next cycle state IDLE, done0=done1=0, res_z=0, busy=0; fresh req served normally afterwards.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared, external combinational ALU: IDLE -> EXEC -> DONE per op.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [3:0]       code0,
  input  logic [3:0]       code1,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] y1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res_z,
  output logic             res_cmp,
  output logic             busy,
  output logic [3:0]       alu_code,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_cmp
);

  localparam logic [3:0] ALU_NOP = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e           state_q, state_d;
  logic [3:0]       code_q, code_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             win_q, win_d;
  logic [WIDTH-1:0] res_z_q, res_z_d;
  logic             res_cmp_q, res_cmp_d;
  logic             grant;
  logic             win_sel;

  assign grant = (state_q == IDLE) && (req0 || req1);

`ifdef ALU_ARB_RR_EN
  // ptr_q names the requester that wins a tie; it always moves to the loser of the last grant.
  logic ptr_q, ptr_d;

  always_comb begin
    win_sel = req1 && !req0;
    if (req0 && req1) begin
      win_sel = ptr_q;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = !win_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    win_sel = !req0;
  end
`endif

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    x_d       = x_q;
    y_d       = y_q;
    win_d     = win_q;
    res_z_d   = res_z_q;
    res_cmp_d = res_cmp_q;
    done0     = 1'b0;
    done1     = 1'b0;
    alu_code  = ALU_NOP;
    alu_x     = '0;
    alu_y     = '0;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          win_d   = win_sel;
          code_d  = win_sel ? code1 : code0;
          x_d     = win_sel ? x1 : x0;
          y_d     = win_sel ? y1 : y0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_code  = code_q;
        alu_x     = x_q;
        alu_y     = y_q;
        res_z_d   = alu_z;
        res_cmp_d = alu_cmp;
        state_d   = DONE;
      end
      DONE: begin
        done0   = !win_q;
        done1   = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      code_q    <= ALU_NOP;
      x_q       <= '0;
      y_q       <= '0;
      win_q     <= 1'b0;
      res_z_q   <= '0;
      res_cmp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      x_q       <= x_d;
      y_q       <= y_d;
      win_q     <= win_d;
      res_z_q   <= res_z_d;
      res_cmp_q <= res_cmp_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign res_z   = res_z_q;
  assign res_cmp = res_cmp_q;

endmodule
